// File: rtl/bitwise_reducer.sv
// bitwise_reducer: folds a burst of N-bit operands into one N-bit result
// using AND / OR / XOR / NAND, with valid/ready handshakes on both sides.
// A burst ends on in_last or when MAX_BEATS beats have been folded.
module bitwise_reducer #(
    parameter int unsigned N         = 8,
    parameter int unsigned MAX_BEATS = 16,
    localparam int unsigned CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    input  logic [1:0]    in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_trunc
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [1:0]     op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]  out_count_q, out_count_d;
    logic           out_trunc_q, out_trunc_d;

    logic           xfer;
    logic           finish;
    logic [1:0]     fold_op;
    logic [N-1:0]   fold;
    logic [CW-1:0]  cnt_next;

    // State register and all datapath flops, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            op_q        <= 2'b00;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_trunc_q <= out_trunc_d;
        end
    end

    // Fold the accepted beat into the accumulator; latch the result when the burst ends
    always_comb begin
        xfer     = in_valid && (state_q != HOLD);
        fold_op  = (state_q == IDLE) ? in_op : op_q;
        cnt_next = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);

        if (state_q == IDLE) begin
            fold = in_data;
        end else begin
            case (op_q)
                2'b01:   fold = acc_q | in_data;
                2'b10:   fold = acc_q ^ in_data;
                default: fold = acc_q & in_data; // AND, and NAND before final inversion
            endcase
        end

        finish = xfer && (in_last || (cnt_next == CW'(MAX_BEATS)));

        acc_d       = acc_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_trunc_d = out_trunc_q;

        if (xfer) begin
            acc_d = fold;
            op_d  = fold_op;
            cnt_d = cnt_next;
        end
        if (finish) begin
            out_data_d  = (fold_op == 2'b11) ? ~fold : fold;
            out_count_d = cnt_next;
            // Ending without in_last can only mean the beat limit was hit
            out_trunc_d = !in_last;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, ACCUM: begin
                if (finish) begin
                    state_d = HOLD;
                end else if (xfer) begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only; result outputs come straight from flops
    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        out_data  = out_data_q;
        out_count = out_count_q;
        out_trunc = out_trunc_q;
    end

endmodule
